// File: rtl/bus_arbiter.sv
// Two-master wishbone arbiter: grants one master at a time, one transaction outstanding,
// and converts a hung slave into an error ack after TIMEOUT_CYCLES cycles in REQ/WAIT.
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter bit ROUND_ROBIN    = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_m0_stb,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_data,
  input  logic        i_m0_we,
  input  logic [2:0]  i_m0_sel,
  output logic [31:0] o_m0_data,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  output logic        o_m0_stall,
  input  logic        i_m1_stb,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_data,
  input  logic        i_m1_we,
  input  logic [2:0]  i_m1_sel,
  output logic [31:0] o_m1_data,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  output logic        o_m1_stall,
  output logic        o_wb_stb,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic        o_wb_we,
  output logic [2:0]  o_wb_sel,
  input  logic [31:0] i_wb_data,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  output logic [1:0]  o_dbg_state
);
  // Handshake: a master request transfers in a cycle where its stb=1 and its stall=0;
  // ack (with err/data) is a single-cycle pulse, combinational from the bus ack.

  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam int TW = TMO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

  state_t          state_q, state_d;
  logic            grant_q, grant_d;
  logic            last_q, last_d;
  logic [TW-1:0]   tmo_q, tmo_d;

  logic [1:0]  req;
  logic        idle_sel, fwd_idx, fwd_stb, accept, tmo_hit;
  logic [31:0] fwd_addr, fwd_data;
  logic        fwd_we;
  logic [2:0]  fwd_sel;

  logic        bus_stb, bus_we;
  logic [31:0] bus_addr, bus_data, resp_data;
  logic [2:0]  bus_sel;
  logic [1:0]  stall_v, ack_v, err_v;

  assign req = {i_m1_stb, i_m0_stb};

  always_comb begin
    if (req == 2'b11) idle_sel = ROUND_ROBIN ? ~last_q : 1'b1;
    else              idle_sel = req[1];
    // Once a master owns the bus it keeps it until ack or timeout.
    fwd_idx  = (state_q == S_IDLE) ? idle_sel : grant_q;
    fwd_stb  = req[fwd_idx];
    fwd_addr = fwd_idx ? i_m1_addr : i_m0_addr;
    fwd_data = fwd_idx ? i_m1_data : i_m0_data;
    fwd_we   = fwd_idx ? i_m1_we   : i_m0_we;
    fwd_sel  = fwd_idx ? i_m1_sel  : i_m0_sel;
    accept   = fwd_stb & ~i_wb_stall;
    tmo_hit  = TMO_EN && (tmo_q == TMO_LAST);
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    tmo_d     = tmo_q;
    bus_stb   = 1'b0;
    bus_addr  = '0;
    bus_data  = '0;
    bus_we    = 1'b0;
    bus_sel   = '0;
    stall_v   = 2'b11;
    ack_v     = 2'b00;
    err_v     = 2'b00;
    resp_data = '0;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          bus_stb  = 1'b1;
          bus_addr = fwd_addr;
          bus_data = fwd_data;
          bus_we   = fwd_we;
          bus_sel  = fwd_sel;
          stall_v[idle_sel] = i_wb_stall;
          if (accept && i_wb_ack) begin
            ack_v[idle_sel] = 1'b1;
            resp_data       = i_wb_data;
            last_d          = idle_sel;
          end else begin
            grant_d = idle_sel;
            tmo_d   = '0;
            state_d = accept ? S_WAIT : S_REQ;
          end
        end
      end
      S_REQ: begin
        bus_stb  = fwd_stb;
        bus_addr = fwd_addr;
        bus_data = fwd_data;
        bus_we   = fwd_we;
        bus_sel  = fwd_sel;
        stall_v[grant_q] = i_wb_stall;
        if (accept && i_wb_ack) begin
          ack_v[grant_q] = 1'b1;
          resp_data      = i_wb_data;
          last_d         = grant_q;
          state_d        = S_IDLE;
        end else if (tmo_hit) begin
          // Withdraw the strobe so the slave cannot take a request we are abandoning.
          bus_stb          = 1'b0;
          stall_v[grant_q] = 1'b1;
          ack_v[grant_q]   = 1'b1;
          err_v[grant_q]   = 1'b1;
          resp_data        = 32'hFFFF_FFFF;
          last_d           = grant_q;
          state_d          = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (accept) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_wb_ack) begin
          ack_v[grant_q] = 1'b1;
          resp_data      = i_wb_data;
          last_d         = grant_q;
          state_d        = S_IDLE;
        end else if (tmo_hit) begin
          ack_v[grant_q] = 1'b1;
          err_v[grant_q] = 1'b1;
          resp_data      = 32'hFFFF_FFFF;
          last_d         = grant_q;
          state_d        = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
    end
  end

  // Reset gates every output combinationally so nothing leaks while the line is low.
  assign o_wb_stb    = i_reset & bus_stb;
  assign o_wb_addr   = i_reset ? bus_addr : '0;
  assign o_wb_data   = i_reset ? bus_data : '0;
  assign o_wb_we     = i_reset & bus_we;
  assign o_wb_sel    = i_reset ? bus_sel : '0;
  assign o_m0_stall  = ~i_reset | stall_v[0];
  assign o_m1_stall  = ~i_reset | stall_v[1];
  assign o_m0_ack    = i_reset & ack_v[0];
  assign o_m1_ack    = i_reset & ack_v[1];
  assign o_m0_err    = i_reset & err_v[0];
  assign o_m1_err    = i_reset & err_v[1];
  assign o_m0_data   = (i_reset && ack_v[0]) ? resp_data : '0;
  assign o_m1_data   = (i_reset && ack_v[1]) ? resp_data : '0;
  assign o_dbg_state = state_q;

endmodule
